bf16_intcast_sched: RTL
=======================

BF16_INTCAST_SCHED -- requirements
Module: bf16_intcast_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one BF16-to-INT16 cast unit (2..8).
REQ-002 The block SHALL have parameter LATENCY, default 1: fixed cycles from cast operand issue to result sample (1..4).

Ports (name, direction, width, meaning):
REQ-003 clk  in  1  the single clock; all state is updated on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-006 req_data  in  16*NUM_REQ  BF16 operands; requester i uses bits [16i+15:16i].
REQ-007 req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 cast_in_valid  out  1  operand issued to the external cast unit this cycle.
REQ-009 cast_in_data  out  16  BF16 operand issued to the cast unit.
REQ-010 cast_out_data  in  16  INT16 result, valid exactly LATENCY cycles after the matching issue.
REQ-011 cast_out_status  in  5  exception flags {NV,DZ,OF,UF,NX} aligned with cast_out_data.
REQ-012 resp_valid  out  NUM_REQ  per-requester result valid.
REQ-013 resp_data  out  16*NUM_REQ  INT16 results, same slicing as req_data.
REQ-014 resp_status  out  5*NUM_REQ  flags per requester.
REQ-015 resp_ready  in  NUM_REQ  per-requester result accept.
REQ-016 issue_count  out  32  total operands issued since reset.

Function
REQ-017 Requester i SHALL be eligible when req_valid[i]=1 and its busy[i] bit is 0; busy[i] is a registered bit.
REQ-018 Among eligible requesters, one grant per cycle SHALL be made by round-robin, starting the search at rr_ptr and wrapping from NUM_REQ-1 to 0.
REQ-019 On a grant to i: req_ready[i]=1 (combinational from req_valid and registered state), cast_in_valid=1, cast_in_data=req_data[i], busy[i] set next cycle, rr_ptr set to (i+1) mod NUM_REQ next cycle.
REQ-020 With no eligible requester: cast_in_valid=0, cast_in_data=0, rr_ptr unchanged.
REQ-021 A LATENCY-deep tag pipeline SHALL carry {valid, requester id} alongside each issue.
REQ-022 When a tag reaches the last stage, cast_out_data/status SHALL be captured into requester id's result slot, with resp_valid[id]=1 from the next cycle.
REQ-023 resp_valid[i], resp_data[i] and resp_status[i] SHALL hold stable until resp_ready[i]=1.
REQ-024 On the handshake (resp_valid[i]&resp_ready[i]), resp_valid[i] and busy[i] SHALL clear next cycle; requester i is eligible from that next cycle onward, never in the handshake cycle itself.
REQ-025 Each requester SHALL have at most one operand in flight, so a result slot can never overflow; no backpressure reaches the cast unit.
REQ-026 issue_count SHALL increment by 1 per issue and wrap from 2^32-1 to 0.
REQ-027 Results SHALL be routed by tag only; issue order and response order across requesters are independent.

Reset
REQ-028 While rst=1 at a clock edge: busy=0, rr_ptr=0, all tag-stage valids=0, resp_valid=0, resp_data=0, resp_status=0, issue_count=0.
REQ-029 During any cycle with rst=1, req_ready and cast_in_valid SHALL be 0.
REQ-030 Operations in flight at reset SHALL be discarded; their later cast_out values SHALL be ignored.

Structure
REQ-031 Package bf16_cast_pkg SHALL hold the status-flag typedef (5-bit struct NV/DZ/OF/UF/NX), the NUM_REQ and LATENCY defaults, and the requester-id width function.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: eligible vector and pointer; outputs: one-hot grant and index).
REQ-033 The cast unit SHALL stay external, so that it can be swapped for other conversion units.

Verification
REQ-034 Single request: req_valid=0001, data 0x4120 (10.0), LATENCY=1 -> req_ready=0001 in the same cycle; resp_valid[0] two cycles later with resp_data=0x000A and status=0.
REQ-035 All four requesters asserted continuously, resp_ready=1111 -> grants 0,1,2,3 in consecutive cycles, each requester re-granted only after its handshake; issue_count=4 after the first four grants.
REQ-036 resp_ready[2]=0 for 10 cycles with req_valid[2] held -> requester 2 is never re-granted and resp_data[2] is stable throughout; 2 is granted in the cycle after resp_ready[2] rises.
REQ-037 Operand 0x7F80 (+inf) -> resp_data=0x7FFF and resp_status NV bit set for that requester only.
REQ-038 rst asserted one cycle after an issue -> no resp_valid appears afterwards; all outputs are zero, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/bf16_cast_pkg.sv
// rtl/bf16_cast_pkg.sv - shared types, defaults and helpers for the BF16 cast scheduler
package bf16_cast_pkg;

    // Exception flags returned by the cast unit, MSB first: {NV,DZ,OF,UF,NX}
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } cast_status_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LATENCY = 1;

    // Width of a requester index; never narrower than one bit
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of one eligible requester starting at a pointer
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          found
);

    int cand;

    // Scan from ptr upward, wrapping at N-1, and take the first eligible requester
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/bf16_intcast_sched.sv
// rtl/bf16_intcast_sched.sv - shares one external BF16-to-INT16 cast unit among requesters
module bf16_intcast_sched
    import bf16_cast_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   cast_in_valid,
    output logic [15:0]            cast_in_data,
    input  logic [15:0]            cast_out_data,
    input  logic [4:0]             cast_out_status,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [16*NUM_REQ-1:0]  resp_data,
    output logic [5*NUM_REQ-1:0]   resp_status,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [31:0]            issue_count
);

    localparam int IW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]             busy;
    logic [IW-1:0]                  rr_ptr;
    logic [LATENCY-1:0]             tag_valid;
    logic [LATENCY-1:0][IW-1:0]     tag_id;
    logic [NUM_REQ-1:0]             resp_valid_q;
    logic [NUM_REQ-1:0][15:0]       resp_data_q;
    cast_status_t [NUM_REQ-1:0]     resp_status_q;

    logic [NUM_REQ-1:0]             eligible;
    logic [NUM_REQ-1:0]             grant;
    logic [IW-1:0]                  grant_idx;
    logic                           grant_found;
    logic [NUM_REQ-1:0]             handshake;

    // A requester stays ineligible from its grant until its result is taken,
    // which bounds in-flight work to one operand per result slot.
    assign eligible  = req_valid & ~busy & {NUM_REQ{~rst}};
    assign handshake = resp_valid_q & resp_ready;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant),
        .index    (grant_idx),
        .found    (grant_found)
    );

    assign req_ready     = grant;
    assign cast_in_valid = grant_found;
    assign cast_in_data  = grant_found ? req_data[int'(grant_idx)*16 +: 16] : 16'h0000;

    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_status = resp_status_q;

    // Busy bits and round-robin pointer; grant and handshake never hit the same bit
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            rr_ptr <= '0;
        end else begin
            busy <= (busy & ~handshake) | grant;
            if (grant_found) begin
                rr_ptr <= IW'((int'(grant_idx) + 1) % NUM_REQ);
            end
        end
    end

    // Tag pipeline tracking which requester owns each operand inside the cast unit
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            for (int s = LATENCY - 1; s > 0; s--) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
            tag_valid[0] <= grant_found;
            tag_id[0]    <= grant_idx;
        end
    end

    // Result slots: captured when a tag retires, held until the requester accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
            resp_status_q <= '0;
        end else begin
            resp_valid_q <= resp_valid_q & ~handshake;
            if (tag_valid[LATENCY-1]) begin
                resp_valid_q[tag_id[LATENCY-1]]  <= 1'b1;
                resp_data_q[tag_id[LATENCY-1]]   <= cast_out_data;
                resp_status_q[tag_id[LATENCY-1]] <= cast_status_t'(cast_out_status);
            end
        end
    end

    // Free-running count of issued operands, wrapping naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_count <= '0;
        end else if (grant_found) begin
            issue_count <= issue_count + 32'd1;
        end
    end

endmodule
